// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - valid/ready byte in, MSB-first serial out with per-bit shift strobe
module byte_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       serial_out,
    output logic       shift_enable,
    output logic       byte_done,
    output logic       busy
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic          FAST     = 1'(CLK_DIV == 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [7:0]    hold;
    logic [7:0]    shreg;
    logic          hold_full;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          accept;
    logic          last_strobe;
    logic          load;
    logic          div_next_last;

    assign in_ready      = !hold_full;
    assign accept        = in_valid && !hold_full;
    assign last_strobe   = (state == SHIFT) && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
    // The held byte moves into the shifter either from idle or straight off the last strobe.
    assign load          = hold_full && ((state == IDLE) || last_strobe);
    assign div_next_last = ((div_cnt + DW'(1)) == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold         <= 8'd0;
            hold_full    <= 1'b0;
            shreg        <= 8'd0;
            bit_cnt      <= 3'd0;
            div_cnt      <= '0;
            serial_out   <= 1'b0;
            shift_enable <= 1'b0;
            byte_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end

            if (load) begin
                state        <= SHIFT;
                shreg        <= hold;
                bit_cnt      <= 3'd0;
                div_cnt      <= '0;
                busy         <= 1'b1;
                serial_out   <= hold[7];
                shift_enable <= FAST;
                byte_done    <= 1'b0;
            end else if (state == SHIFT) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    shreg   <= shreg << 1;
                    if (bit_cnt == 3'd7) begin
                        state        <= IDLE;
                        bit_cnt      <= 3'd0;
                        busy         <= 1'b0;
                        shift_enable <= 1'b0;
                        byte_done    <= 1'b0;
                    end else begin
                        bit_cnt      <= bit_cnt + 3'd1;
                        serial_out   <= shreg[6];
                        shift_enable <= FAST;
                        byte_done    <= FAST && (bit_cnt == 3'd6);
                    end
                end else begin
                    // Strobe flags are registered, so they are raised one edge ahead of the sample cycle.
                    div_cnt      <= div_cnt + DW'(1);
                    shift_enable <= div_next_last;
                    byte_done    <= div_next_last && (bit_cnt == 3'd7);
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - randomized and directed bench for byte_serializer against a timeline model
module tb_byte_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam int DIV [2] = '{4, 1};

    logic [7:0] in_data [2];
    logic       in_valid [2];
    logic       in_ready [2];
    logic       serial_out [2];
    logic       shift_enable [2];
    logic       byte_done [2];
    logic       busy [2];

    byte_serializer #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .serial_out(serial_out[0]), .shift_enable(shift_enable[0]),
        .byte_done(byte_done[0]), .busy(busy[0]));

    byte_serializer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .serial_out(serial_out[1]), .shift_enable(shift_enable[1]),
        .byte_done(byte_done[1]), .busy(busy[1]));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Model: a byte occupies 8*D cycles after its load edge; cycle t carries bit 7-t/D.
    bit         m_act [2]    = '{0, 0};
    bit         m_hold_v [2] = '{0, 0};
    logic [7:0] m_hold [2]   = '{8'd0, 8'd0};
    logic [7:0] m_cur [2]    = '{8'd0, 8'd0};
    int         m_t [2]      = '{0, 0};
    bit         m_ser [2]    = '{0, 0};
    logic [7:0] sq0 [$];
    logic [7:0] sq1 [$];
    logic [7:0] des [2]      = '{8'd0, 8'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_hold_v[i] = 0; m_t[i] = 0; m_ser[i] = 0;
            end
            sq0.delete();
            sq1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit acc;
                acc = (in_valid[i] === 1'b1) && !m_hold_v[i];
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 8 * DIV[i]) begin
                        if (m_hold_v[i]) begin
                            m_cur[i] = m_hold[i]; m_hold_v[i] = 0; m_t[i] = 0;
                        end else begin
                            m_act[i] = 0;
                        end
                    end
                end else if (m_hold_v[i]) begin
                    m_cur[i] = m_hold[i]; m_hold_v[i] = 0; m_act[i] = 1; m_t[i] = 0;
                end
                if (acc) begin
                    m_hold[i] = in_data[i];
                    m_hold_v[i] = 1;
                    if (i == 0) sq0.push_back(in_data[i]); else sq1.push_back(in_data[i]);
                end
                if (m_act[i]) m_ser[i] = m_cur[i][7 - m_t[i] / DIV[i]];
            end
        end
    end

    always @(posedge clk) begin
        #3;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            chk("in_ready", i, 32'(in_ready[i]), 32'(!m_hold_v[i]));
            chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
            chk("shift_enable", i, 32'(shift_enable[i]), 32'(m_act[i] && (m_t[i] % DIV[i] == DIV[i] - 1)));
            chk("byte_done", i, 32'(byte_done[i]), 32'(m_act[i] && (m_t[i] == 8 * DIV[i] - 1)));
            chk("serial_out", i, 32'(serial_out[i]), 32'(m_ser[i]));
            if (!rst_n) begin
                des[i] = 8'd0;
            end else begin
                if (shift_enable[i] === 1'b1) des[i] = {des[i][6:0], serial_out[i]};
                if (byte_done[i] === 1'b1) begin
                    if ((i == 0 && sq0.size() == 0) || (i == 1 && sq1.size() == 0)) begin
                        chk("loopback_extra", i, 32'd1, 32'd0);
                    end else begin
                        e = (i == 0) ? sq0.pop_front() : sq1.pop_front();
                        chk("loopback", i, 32'(des[i]), 32'(e));
                    end
                end
            end
        end
    end

    task automatic send_meas(input int idx, input logic [7:0] b [4], input int nb,
                             output int lat, output int span, output int nstb,
                             output logic [31:0] bits, output int run, output logic busy_after);
        int k, dones, sent, first, cur_run;
        k = 0; dones = 0; sent = 0; first = -1; cur_run = 0;
        lat = -1; span = -1; nstb = 0; bits = 0; run = 0;
        while (dones < nb && k < 400) begin
            @(negedge clk);
            if (sent < nb) begin
                in_valid[idx] = 1'b1;
                in_data[idx] = b[sent];
                if (in_ready[idx] === 1'b1) sent++;
            end else begin
                in_valid[idx] = 1'b0;
                in_data[idx] = 8'($urandom);
            end
            @(posedge clk);
            #3;
            k++;
            if (shift_enable[idx] === 1'b1) begin
                nstb++;
                bits = {bits[30:0], serial_out[idx]};
                if (first < 0) begin
                    first = k;
                    lat = k - 1;
                end
                cur_run++;
                if (cur_run > run) run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (byte_done[idx] === 1'b1) begin
                dones++;
                if (dones == nb) span = k - first;
            end
        end
        chk("send_timeout", idx, 32'(dones), 32'(nb));
        @(negedge clk);
        in_valid[idx] = 1'b0;
        @(posedge clk);
        #3;
        busy_after = busy[idx];
    endtask

    initial begin
        int lat, span, nstb, run, n, k;
        logic [31:0] bits;
        logic ba;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        in_data[0] = 8'd0; in_data[1] = 8'd0;

        repeat (3) @(posedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("t1_in_ready", i, 32'(in_ready[i]), 32'd1);
            chk("t1_busy", i, 32'(busy[i]), 32'd0);
            chk("t1_strobe", i, 32'(shift_enable[i]), 32'd0);
            chk("t1_serial", i, 32'(serial_out[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_meas(0, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1, lat, span, nstb, bits, run, ba);
        chk("t2_latency", 0, 32'(lat), 32'd4);
        chk("t2_span", 0, 32'(span), 32'd28);
        chk("t2_strobes", 0, 32'(nstb), 32'd8);
        chk("t2_bits", 0, bits, 32'hA5);
        chk("t2_busy_after", 0, 32'(ba), 32'd0);
        repeat (4) @(negedge clk);

        send_meas(0, '{8'h3C, 8'hC3, 8'h00, 8'h00}, 2, lat, span, nstb, bits, run, ba);
        chk("t3_span", 0, 32'(span), 32'd60);
        chk("t3_strobes", 0, 32'(nstb), 32'd16);
        chk("t3_bits", 0, bits, 32'h3CC3);
        repeat (4) @(negedge clk);

        send_meas(0, '{8'h3C, 8'hC3, 8'h5A, 8'h00}, 3, lat, span, nstb, bits, run, ba);
        chk("t4_span", 0, 32'(span), 32'd92);
        chk("t4_bits", 0, bits, 32'h3CC35A);
        repeat (4) @(negedge clk);

        send_meas(1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 2, lat, span, nstb, bits, run, ba);
        chk("t5_latency", 1, 32'(lat), 32'd1);
        chk("t5_run", 1, 32'(run), 32'd16);
        chk("t5_bits", 1, bits, 32'hFF00);
        repeat (4) @(negedge clk);

        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0] = 8'hE7;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0; k = 0;
        while (n < 3 && k < 100) begin
            @(posedge clk);
            #3;
            if (shift_enable[0] === 1'b1) n++;
            k++;
        end
        chk("t6_reach_bit3", 0, 32'(n), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        chk("t6_busy_after_rst", 0, 32'(busy[0]), 32'd0);
        chk("t6_ready_after_rst", 0, 32'(in_ready[0]), 32'd1);
        send_meas(0, '{8'h96, 8'h00, 8'h00, 8'h00}, 1, lat, span, nstb, bits, run, ba);
        chk("t6_bits", 0, bits, 32'h96);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_data[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        repeat (80) @(negedge clk);
        chk("drain", 0, 32'(sq0.size() + sq1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
